// File: rtl/ps2_keyboard_receiver_if.sv
// Keyboard-side pins and consumer handshake for the PS/2 receiver.
// slave = receiver side, master = keyboard/consumer side.
interface ps2_keyboard_receiver_if;
  logic        iKey_Clock;
  logic        iKey_Data;
  logic        iData_Received;
  logic [10:0] oKey_Data_Out;
  logic        oData_Ready;
  logic        oFrame_Error;
  logic        oOverrun;

  modport slave (
    input  iKey_Clock,
    input  iKey_Data,
    input  iData_Received,
    output oKey_Data_Out,
    output oData_Ready,
    output oFrame_Error,
    output oOverrun
  );

  modport master (
    output iKey_Clock,
    output iKey_Data,
    output iData_Received,
    input  oKey_Data_Out,
    input  oData_Ready,
    input  oFrame_Error,
    input  oOverrun
  );
endinterface

// File: rtl/ps2_keyboard_receiver.sv
// PS/2 keyboard frame receiver: synchronizes the pins, shifts 11-bit
// frames, checks start/stop/odd parity and hands frames to a consumer.
module ps2_keyboard_receiver #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                    Clock,
  input  logic                    Reset,
  ps2_keyboard_receiver_if.slave  kbd
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } state_t;

  state_t      state, stateNext;
  logic [1:0]  clkSync, datSync;
  logic        clkPrev;
  logic [3:0]  bitCnt, bitCntNext;
  logic [CW-1:0] toCnt, toCntNext;
  logic [10:0] shiftReg, shiftNext;
  logic [10:0] dataOut, dataOutNext;
  logic        ready, readyNext;
  logic        frameErr, frameErrNext;
  logic        overrun, overrunNext;
  logic        fall, bitIn, frameOk, load;

  // Synchronizers idle high so reset never fakes a falling edge
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      clkSync <= 2'b11;
      datSync <= 2'b11;
      clkPrev <= 1'b1;
    end else begin
      clkSync <= {clkSync[0], kbd.iKey_Clock};
      datSync <= {datSync[0], kbd.iKey_Data};
      clkPrev <= clkSync[1];
    end
  end

  assign fall    = clkPrev & ~clkSync[1];
  assign bitIn   = datSync[1];
  assign frameOk = ~shiftReg[0] & shiftReg[10] & (^shiftReg[9:1]);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      bitCnt   <= '0;
      toCnt    <= '0;
      shiftReg <= '0;
      dataOut  <= '0;
      ready    <= 1'b0;
      frameErr <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= stateNext;
      bitCnt   <= bitCntNext;
      toCnt    <= toCntNext;
      shiftReg <= shiftNext;
      dataOut  <= dataOutNext;
      ready    <= readyNext;
      frameErr <= frameErrNext;
      overrun  <= overrunNext;
    end
  end

  always_comb begin
    stateNext    = state;
    bitCntNext   = bitCnt;
    toCntNext    = toCnt;
    shiftNext    = shiftReg;
    dataOutNext  = dataOut;
    readyNext    = ready;
    frameErrNext = 1'b0;
    overrunNext  = overrun;
    load         = 1'b0;

    unique case (state)
      IDLE: begin
        bitCntNext = '0;
        toCntNext  = '0;
        if (fall && !bitIn) begin
          shiftNext  = {bitIn, 10'd0};
          bitCntNext = 4'd1;
          stateNext  = SHIFT;
        end
      end
      SHIFT: begin
        if (fall) begin
          shiftNext  = {bitIn, shiftReg[10:1]};
          bitCntNext = bitCnt + 4'd1;
          toCntNext  = '0;
          if (bitCnt == 4'd10) stateNext = CHECK;
        end else if (toCnt == CW'(TIMEOUT_CYCLES - 1)) begin
          frameErrNext = 1'b1;
          stateNext    = IDLE;
          bitCntNext   = '0;
          toCntNext    = '0;
          shiftNext    = '0;
        end else begin
          toCntNext = toCnt + 1'b1;
        end
      end
      CHECK: begin
        stateNext  = IDLE;
        bitCntNext = '0;
        toCntNext  = '0;
        if (!frameOk) begin
          frameErrNext = 1'b1;
        end else if (!ready || kbd.iData_Received) begin
          load        = 1'b1;
          dataOutNext = shiftReg;
          readyNext   = 1'b1;
        end else begin
          overrunNext = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase

    if (ready && kbd.iData_Received && !load) readyNext = 1'b0;
  end

  assign kbd.oKey_Data_Out = dataOut;
  assign kbd.oData_Ready   = ready;
  assign kbd.oFrame_Error  = frameErr;
  assign kbd.oOverrun      = overrun;

endmodule
